md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//   Multiply/divide unit with architectural HI/LO registers for the MIPS core.
//   - Sits in EX, directly downstream of the general register file read ports:
//     operand A is rs data (RD1), operand B is rt data (RD2).
//   - Runs mult/multu/div/divu over several cycles; busy output lets the hazard logic stall mfhi/mflo/md ops.
//   - HI/LO are exposed for mfhi/mflo, whose result returns to the register file write port.
// PARAMETERS
//   MULT_CYCLES  5   cycles busy stays high for mult/multu (>=1)
//   DIV_CYCLES   10  cycles busy stays high for div/divu (>=1)
// PORTS
//   clk    input   1   system clock; all state changes on rising edge
//   rst    input   1   reset; one clock, reset is asynchronous and active-low
//   start  input   1   op valid this cycle (EX-stage instruction is an MD op)
//   op     input   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
//   A      input   32  operand rs (RD1)
//   B      input   32  operand rt (RD2)
//   busy   output  1   operation in progress; registered
//   HI     output  32  HI register; registered
//   LO     output  32  LO register; registered
// BEHAVIOUR
//   Reset (rst low, async)
//     - busy=0, HI=0, LO=0, counter=0, operand/result latches cleared.
//     - Any in-flight op is discarded.
//     - Effect is immediate, not waiting for clk; state held while rst low.
//   States
//     - IDLE (busy=0), RUN (busy=1). Counter cnt: width ceil(log2(max cycles))+1.
//   IDLE, rising edge with start=1
//     - op 1-4: latch A, B and op; cnt<=MULT_CYCLES or DIV_CYCLES; busy<=1; go RUN.
//     - op 5 (mthi): HI<=A, no busy. op 6 (mtlo): LO<=A, no busy.
//     - op 0/7: no effect.
//   RUN, each rising edge
//     - cnt!=1: cnt<=cnt-1.
//     - cnt==1: commit HI/LO from latched operands; busy<=0; go IDLE.
//     - start ignored entirely in RUN (incl. mthi/mtlo); hazard logic must stall. No queuing.
//   Latency
//     - Op accepted at edge k: busy=1 in cycles after edges k..k+N-1.
//     - HI/LO take new value at edge k+N, same edge busy falls. N=MULT_CYCLES or DIV_CYCLES.
//     - HI/LO hold old values throughout RUN; visible to mfhi/mflo only after busy falls.
//   Arithmetic
//     - mult: {HI,LO} = signed 64-bit product of A and B.
//     - multu: {HI,LO} = unsigned 64-bit product of A and B.
//     - div: LO = quotient truncated toward zero; HI = remainder with sign of A (signed).
//     - divu: LO = A/B, HI = A%B (unsigned).
//     - Divide by B==0: full busy period runs; HI/LO left unchanged at commit.
//     - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
//     - Operands computed from latched copies only; A/B changing during RUN has no effect.
//   Simultaneous events
//     - Commit edge with start=1: commit happens; start NOT accepted (busy still 1 at that edge).
//     - rst low overrides everything.
// TESTING
//   1. mult A=0xFFFFFFFD B=5
//      -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
//   2. multu A=0xFFFFFFFF B=2
//      -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
//   3. div A=0xFFFFFFF9 (-7) B=2
//      -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   4. mtlo A=0x1234 then divu A=9 B=0
//      -> LO=0x1234 next edge; after 10 busy cycles HI=0, LO=0x1234 (unchanged).
//   5. multu in RUN + mthi A=0xAAAA issued on 2nd busy cycle
//      -> mthi ignored; final HI/LO = product only.
//      -> start on commit edge also ignored.
//   6. div started, rst pulsed low on 4th busy cycle (mid-clock)
//      -> busy, HI, LO = 0 immediately; no commit after release.

Source files
------------

// File: rtl/md_if.sv
// ---------------------------------------------------------------------------
// md_if
//   Operand/result bundle between the EX stage and the multiply/divide unit.
//   Signals:
//     start  op valid this cycle (EX instruction is an MD op)
//     op     3-bit MD opcode (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//            5 mthi, 6 mtlo, 7 reserved)
//     a, b   operands from register file read ports (rs, rt)
//     busy   unit is running a multi-cycle op
//     hi, lo architectural HI/LO registers
//   Modports:
//     master  EX-stage side (drives start/op/a/b)
//     slave   md_unit side (drives busy/hi/lo)
// ---------------------------------------------------------------------------
interface md_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit
//   Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
//   mult/multu/div/divu latch their operands and keep busy high for a fixed
//   number of cycles, committing HI/LO on the edge busy falls. mthi/mtlo
//   write HI/LO directly when idle. Requests arriving while busy are dropped;
//   the hazard logic upstream is expected to stall them.
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-low reset
//     bus   md_if.slave: start/op/a/b in, busy/hi/lo out (all registered)
// ---------------------------------------------------------------------------
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic rst,
  md_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t         state_r, state_nxt_s;
  logic [CW-1:0]  cnt_r, cnt_nxt_s;
  logic           busy_r, busy_nxt_s;
  logic [31:0]    hi_r, hi_nxt_s;
  logic [31:0]    lo_r, lo_nxt_s;
  logic [2:0]     op_lat_r, op_lat_nxt_s;
  logic [31:0]    a_lat_r, a_lat_nxt_s;
  logic [31:0]    b_lat_r, b_lat_nxt_s;

  logic           md_req_s;
  logic [63:0]    a_ext_s, b_ext_s, prod_s;
  logic           sdiv_s;
  logic [31:0]    a_mag_s, b_mag_s, b_safe_s, q_mag_s, r_mag_s, quot_s, rem_s;

  // An op that needs the multi-cycle datapath (mult/multu/div/divu).
  always_comb begin
    md_req_s = bus.start && (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
  end

  // Arithmetic on the latched operands only; evaluated every cycle, used at commit.
  always_comb begin
    // Sign-extend for mult so a plain 64-bit product gives the two's-complement result.
    a_ext_s = (op_lat_r == OP_MULT) ? {{32{a_lat_r[31]}}, a_lat_r} : {32'd0, a_lat_r};
    b_ext_s = (op_lat_r == OP_MULT) ? {{32{b_lat_r[31]}}, b_lat_r} : {32'd0, b_lat_r};
    prod_s  = a_ext_s * b_ext_s;

    // Signed divide via magnitudes: avoids the -2^31 / -1 overflow case entirely.
    sdiv_s   = (op_lat_r == OP_DIV);
    a_mag_s  = (sdiv_s && a_lat_r[31]) ? (32'd0 - a_lat_r) : a_lat_r;
    b_mag_s  = (sdiv_s && b_lat_r[31]) ? (32'd0 - b_lat_r) : b_lat_r;
    // Divisor forced non-zero so the divider never sees /0; result is discarded then.
    b_safe_s = (b_mag_s == 32'd0) ? 32'd1 : b_mag_s;
    q_mag_s  = a_mag_s / b_safe_s;
    r_mag_s  = a_mag_s % b_safe_s;
    quot_s   = (sdiv_s && (a_lat_r[31] ^ b_lat_r[31])) ? (32'd0 - q_mag_s) : q_mag_s;
    rem_s    = (sdiv_s && a_lat_r[31]) ? (32'd0 - r_mag_s) : r_mag_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (md_req_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values: operand capture, countdown, HI/LO writes.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    busy_nxt_s   = busy_r;
    hi_nxt_s     = hi_r;
    lo_nxt_s     = lo_r;
    op_lat_nxt_s = op_lat_r;
    a_lat_nxt_s  = a_lat_r;
    b_lat_nxt_s  = b_lat_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              op_lat_nxt_s = bus.op;
              a_lat_nxt_s  = bus.a;
              b_lat_nxt_s  = bus.b;
              cnt_nxt_s    = MULT_LOAD;
              busy_nxt_s   = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              op_lat_nxt_s = bus.op;
              a_lat_nxt_s  = bus.a;
              b_lat_nxt_s  = bus.b;
              cnt_nxt_s    = DIV_LOAD;
              busy_nxt_s   = 1'b1;
            end
            OP_MTHI: hi_nxt_s = bus.a;
            OP_MTLO: lo_nxt_s = bus.a;
            default: busy_nxt_s = 1'b0;
          endcase
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      ST_RUN: begin
        // start is deliberately not looked at here, including on the commit edge.
        if (cnt_r != CNT_ONE) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
          cnt_nxt_s  = CNT_ZERO;
          busy_nxt_s = 1'b0;
          case (op_lat_r)
            OP_MULT, OP_MULTU: begin
              hi_nxt_s = prod_s[63:32];
              lo_nxt_s = prod_s[31:0];
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero burns the full busy period but leaves HI/LO alone.
              if (b_lat_r != 32'd0) begin
                hi_nxt_s = rem_s;
                lo_nxt_s = quot_s;
              end else begin
                hi_nxt_s = hi_r;
                lo_nxt_s = lo_r;
              end
            end
            default: begin
              hi_nxt_s = hi_r;
              lo_nxt_s = lo_r;
            end
          endcase
        end
      end
      default: begin
        cnt_nxt_s  = CNT_ZERO;
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r    <= CNT_ZERO;
      busy_r   <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      op_lat_r <= 3'd0;
      a_lat_r  <= 32'd0;
      b_lat_r  <= 32'd0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      busy_r   <= busy_nxt_s;
      hi_r     <= hi_nxt_s;
      lo_r     <= lo_nxt_s;
      op_lat_r <= op_lat_nxt_s;
      a_lat_r  <= a_lat_nxt_s;
      b_lat_r  <= b_lat_nxt_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit
//   Self-checking bench for md_unit. Expected HI/LO/busy-length are computed
//   by a 64-bit behavioural model, queued when an op is driven and popped
//   when busy falls.
// ---------------------------------------------------------------------------
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic  clk;
  logic  rst;
  md_if  bus ();

  exp_t        sb_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          n_cmp;
  int          n_err;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi0,
                                        input logic [31:0] lo0);
    longint      sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = {hi0, lo0};
    case (op)
      OP_MULT:  res = 64'(sa * sb);
      OP_MULTU: res = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b != 32'd0) begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      OP_DIVU: begin
        if (b != 32'd0) res = {a % b, a / b};
      end
      default: res = {hi0, lo0};
    endcase
    return res;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst  = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    rst = 1'b1;
  endtask

  // Single-cycle ops (mthi/mtlo/none/reserved): effect visible after one edge.
  task automatic do_single(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = $urandom;
    if (op == OP_MTHI) m_hi = a;
    else if (op == OP_MTLO) m_lo = a;
    @(negedge clk);
    bus.start = 1'b0;
    chk("single_busy", {31'd0, bus.busy}, 32'd0);
    chk("single_hi", bus.hi, m_hi);
    chk("single_lo", bus.lo, m_lo);
  endtask

  // Multi-cycle op; inject drives mthi on the 2nd busy cycle and on the commit edge.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
    exp_t        e;
    logic [63:0] r;
    int          n, cyc;
    logic [31:0] hold_hi, hold_lo;
    n       = (op == OP_MULT || op == OP_MULTU) ? MULT_N : DIV_N;
    hold_hi = m_hi;
    hold_lo = m_lo;
    r       = model(op, a, b, m_hi, m_lo);
    m_hi    = r[63:32];
    m_lo    = r[31:0];
    e.hi     = m_hi;
    e.lo     = m_lo;
    e.cycles = n;
    sb_q.push_back(e);

    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 64) begin
      cyc++;
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      if (inject && (cyc == 2 || cyc == n)) begin
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.a     = (cyc == 2) ? 32'h0000AAAA : 32'h00005555;
      end
      if (cyc == 2) begin
        chk("run_hi_hold", bus.hi, hold_hi);
        chk("run_lo_hold", bus.lo, hold_lo);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;

    e = sb_q.pop_front();
    chk("busy_cycles", 32'(cyc), 32'(e.cycles));
    chk("commit_hi", bus.hi, e.hi);
    chk("commit_lo", bus.lo, e.lo);
    if (inject) begin
      @(negedge clk);
      chk("post_commit_busy", {31'd0, bus.busy}, 32'd0);
      chk("post_commit_hi", bus.hi, e.hi);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    m_hi      = 32'd0;
    m_lo      = 32'd0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_NONE;
    bus.a     = 32'd0;
    bus.b     = 32'd0;

    @(negedge clk);
    chk("init_busy", {31'd0, bus.busy}, 32'd0);
    chk("init_hi", bus.hi, 32'd0);
    chk("init_lo", bus.lo, 32'd0);
    rst = 1'b1;

    run_md(OP_MULT,  32'hFFFFFFFD, 32'd5, 1'b0);
    run_md(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
    run_md(OP_DIV,   32'hFFFFFFF9, 32'd2, 1'b0);

    apply_reset();
    do_single(OP_MTLO, 32'h00001234);
    run_md(OP_DIVU, 32'd9, 32'd0, 1'b0);

    run_md(OP_MULTU, 32'h00010003, 32'h00020005, 1'b1);

    run_md(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_md(OP_DIV,  32'd7, 32'hFFFFFFFE, 1'b0);
    run_md(OP_DIVU, 32'hFFFFFFFF, 32'd7, 1'b0);
    run_md(OP_MULT, 32'h80000000, 32'h80000000, 1'b0);
    do_single(OP_MTHI, 32'hCAFEF00D);
    do_single(OP_NONE, 32'h11111111);
    do_single(OP_RSVD, 32'h22222222);

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  rop;
      logic [31:0] rb;
      rop = 3'($urandom_range(1, 4));
      rb  = (i == 3) ? 32'd0 : $urandom;
      run_md(rop, $urandom, rb, 1'b0);
    end

    // Async reset in the middle of a divide.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_busy", {31'd0, bus.busy}, 32'd0);
    chk("async_hi", bus.hi, 32'd0);
    chk("async_lo", bus.lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    repeat (DIV_N + 2) @(negedge clk);
    chk("after_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("after_rst_hi", bus.hi, 32'd0);
    chk("after_rst_lo", bus.lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
